// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - async FIFO read-side stage: rinc/rempty pop interface to registered valid/ready stream
// Pops ahead into a small circular prefetch buffer; m_ready never reaches rinc combinationally.
module fifo_rd_stream #(
    parameter int DSIZE     = 8,
    parameter int BUF_DEPTH = 3
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    output logic             rinc,
    input  logic [DSIZE-1:0] rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic [2:0]       buf_cnt
);

    localparam int            IW       = $clog2(BUF_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(BUF_DEPTH - 1);
    localparam logic [3:0]    DEPTH4   = 4'(BUF_DEPTH);

    logic [DSIZE-1:0] mem_q [BUF_DEPTH];
    logic [DSIZE-1:0] mem_d [BUF_DEPTH];
    logic [IW-1:0]    head_q, head_d;
    logic [IW-1:0]    tail_q, tail_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             inflight_q, inflight_d;
    logic             run_q, run_d;
    logic [DSIZE-1:0] m_data_q, m_data_d;

    logic             pop;
    logic             capture;
    logic             transfer;
    logic [3:0]       occ_sum;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        // run_q holds pops off until the first edge after reset release
        occ_sum    = {1'b0, cnt_q} + {3'b000, inflight_q};
        pop        = run_q & ~rempty & (occ_sum < DEPTH4);
        capture    = inflight_q;
        transfer   = (cnt_q != 3'd0) & m_ready;

        run_d      = 1'b1;
        inflight_d = pop;

        mem_d = mem_q;
        if (capture) begin
            mem_d[tail_q] = rdata;
        end

        tail_d = capture  ? wrap_inc(tail_q) : tail_q;
        head_d = transfer ? wrap_inc(head_q) : head_q;
        cnt_d  = cnt_q + {2'b00, capture} - {2'b00, transfer};

        // Head register follows the post-edge head slot, including a word written this edge
        m_data_d = (cnt_d != 3'd0) ? mem_d[head_d] : m_data_q;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= 3'd0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
            m_data_q   <= '0;
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            run_q      <= run_d;
            m_data_q   <= m_data_d;
        end
    end

    assign rinc    = pop;
    assign m_valid = (cnt_q != 3'd0);
    assign m_data  = m_data_q;
    assign buf_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

    logic       clk;
    logic       rrst_n;
    logic       rempty;
    logic       rinc;
    logic [7:0] rdata;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [2:0] buf_cnt;

    int total;
    int bad;

    fifo_rd_stream #(.DSIZE(8), .BUF_DEPTH(3)) dut (
        .rclk    (clk),
        .rrst_n  (rrst_n),
        .rempty  (rempty),
        .rinc    (rinc),
        .rdata   (rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .buf_cnt (buf_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rempty;
        logic       m_ready;
        logic [7:0] rdata;
        logic       e_rinc;
        logic       e_valid;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs [15];

    logic [7:0] src_q [$];
    logic [7:0] got_q [$];
    logic       s_rinc;
    logic       s_valid;
    logic [7:0] s_data;
    logic [2:0] s_cnt;
    int         pops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left just after a rising edge; the source model pops on the edge where rinc was seen
    task automatic stream_cycle();
        @(negedge clk);
        s_rinc  = rinc;
        s_valid = m_valid;
        s_data  = m_data;
        s_cnt   = buf_cnt;
        @(posedge clk);
        #1;
        if (s_rinc) begin
            pops++;
            chk("pop_nonempty", 32'(src_q.size() != 0), 32'd1);
            if (src_q.size() != 0) rdata = src_q.pop_front();
        end else begin
            rdata = 8'hEE;
        end
        rempty = (src_q.size() == 0);
    endtask

    task automatic run_collect(input int ncyc, output int first_v, output int last_v);
        first_v = -1;
        last_v  = -1;
        got_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            stream_cycle();
            if (s_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                got_q.push_back(s_data);
            end
        end
    endtask

    int fv;
    int lv;

    initial begin
        total   = 0;
        bad     = 0;
        pops    = 0;
        rrst_n  = 1'b0;
        rempty  = 1'b1;
        m_ready = 1'b0;
        rdata   = 8'h00;

        // {rempty, m_ready, rdata, exp rinc, exp m_valid, exp m_data, exp buf_cnt}
        vecs[0]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0};
        vecs[1]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 3'd0};
        vecs[2]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd1};
        vecs[3]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 3'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'hB0, 1'b1, 1'b0, 8'hA5, 3'd0};
        vecs[6]  = '{1'b0, 1'b0, 8'hB1, 1'b1, 1'b1, 8'hB0, 3'd1};
        vecs[7]  = '{1'b0, 1'b0, 8'hB2, 1'b0, 1'b1, 8'hB0, 3'd2};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 3'd3};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 3'd3};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hB0, 3'd3};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hB1, 3'd2};
        vecs[12] = '{1'b1, 1'b1, 8'hB3, 1'b0, 1'b1, 8'hB2, 3'd1};
        vecs[13] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hB3, 3'd1};
        vecs[14] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hB3, 3'd0};

        #1;
        chk("rst_rinc", 32'(rinc), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_cnt", 32'(buf_cnt), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rrst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_rinc", 32'(rinc), 32'd0);
            chk("idle_valid", 32'(m_valid), 32'd0);
            chk("idle_cnt", 32'(buf_cnt), 32'd0);
            chk("idle_data", 32'(m_data), 32'd0);
            @(posedge clk);
            #1;
        end

        // Single word then back-pressure fill and drain
        for (int i = 0; i < 15; i++) begin
            rempty  = vecs[i].rempty;
            m_ready = vecs[i].m_ready;
            rdata   = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d_rinc", i), 32'(rinc), 32'(vecs[i].e_rinc));
            chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d_cnt", i), 32'(buf_cnt), 32'(vecs[i].e_cnt));
            @(posedge clk);
            #1;
        end

        // Streaming 0x00..0x0F at full rate
        src_q.delete();
        for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
        rempty  = 1'b0;
        m_ready = 1'b1;
        rdata   = 8'hEE;
        run_collect(30, fv, lv);
        chk("stream_first_valid", 32'(fv), 32'd2);
        chk("stream_last_valid", 32'(lv), 32'd17);
        chk("stream_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            chk($sformatf("stream_word%0d", i), 32'(got_q[i]), 32'(i));
        end

        // Source runs dry after 0x05
        src_q.delete();
        for (int i = 0; i < 6; i++) src_q.push_back(8'(i));
        rempty = 1'b0;
        pops   = 0;
        run_collect(20, fv, lv);
        chk("dry_count", 32'(got_q.size()), 32'd6);
        chk("dry_last_valid", 32'(lv), 32'd7);
        chk("dry_pops", 32'(pops), 32'd6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            chk($sformatf("dry_word%0d", i), 32'(got_q[i]), 32'(i));
        end
        chk("dry_end_valid", 32'(m_valid), 32'd0);
        chk("dry_end_rinc", 32'(rinc), 32'd0);

        // Async reset with two buffered words and one in flight
        src_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(8'h20 + 8'(i));
        rempty  = 1'b0;
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) stream_cycle();
        chk("pre_rst_cnt", 32'(buf_cnt), 32'd2);
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_cnt", 32'(buf_cnt), 32'd0);
        chk("mid_rst_data", 32'(m_data), 32'd0);
        chk("mid_rst_rinc", 32'(rinc), 32'd0);
        src_q.delete();
        src_q.push_back(8'h30);
        src_q.push_back(8'h31);
        rempty  = 1'b0;
        rdata   = 8'hEE;
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("in_rst_rinc", 32'(rinc), 32'd0);
            chk("in_rst_cnt", 32'(buf_cnt), 32'd0);
        end
        rrst_n = 1'b1;
        @(posedge clk);
        #1;
        run_collect(12, fv, lv);
        chk("post_rst_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() > 0) chk("post_rst_first", 32'(got_q[0]), 32'h30);
        else chk("post_rst_first_seen", 32'd0, 32'd1);
        if (got_q.size() > 1) chk("post_rst_second", 32'(got_q[1]), 32'h31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
